// File: rtl/handshake_receiver.sv
// handshake_receiver
//   Receive-side endpoint of a 4-phase req/ack clock-domain-crossing handshake.
//   Everything here runs in the in_clk domain.
//   - in_req is brought into this domain through a SYNC_STAGES-deep flop chain.
//   - in_data is captured on the IDLE->VALID edge. The sender holds it stable
//     while req is high, so it is not synchronized.
//   - The captured word is offered downstream on out_valid/in_ready.
//   - When downstream accepts the word, out_ack is raised back to the sender.
//   - out_count counts accepted words. out_err flags a req that drops before
//     the word has been accepted.
// Ports
//   in_clk, in_reset_n : receive clock; async active-low reset
//   in_req, in_data    : sender request level and data word (asynchronous)
//   out_ack            : acknowledge level to the sender (registered)
//   out_data,out_valid : captured word and its valid flag
//   in_ready           : downstream accepts out_data
//   out_err            : one-cycle pulse when req drops while VALID
//   out_count          : accepted transfers, wrapping counter
module handshake_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  in_clk,
  input  logic                  in_reset_n,
  input  logic                  in_req,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  out_count
);

  localparam int IW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {INIT, IDLE, VALID, ACK} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    req_s;
  logic [IW-1:0]           init_cnt, init_cnt_nxt;
  logic                    err_seen, err_seen_nxt;
  logic                    ack_nxt, valid_nxt, err_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic [CNT_WIDTH-1:0]    count_nxt;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) sync_q <= '0;
    else             sync_q <= {sync_q[SYNC_STAGES-2:0], in_req};
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    err_seen_nxt = err_seen;
    ack_nxt      = out_ack;
    valid_nxt    = out_valid;
    data_nxt     = out_data;
    count_nxt    = out_count;
    err_nxt      = 1'b0;
    case (state)
      // Flush the synchronizer first. Then require req_s to be low, so that a
      // req held high across reset is not taken as a new transfer.
      INIT: begin
        ack_nxt   = 1'b0;
        valid_nxt = 1'b0;
        if (init_cnt != IW'(SYNC_STAGES)) init_cnt_nxt = init_cnt + IW'(1);
        else if (!req_s)                  state_nxt    = IDLE;
      end
      IDLE: begin
        ack_nxt = 1'b0;
        if (req_s) begin
          data_nxt     = in_data;
          valid_nxt    = 1'b1;
          err_seen_nxt = 1'b0;
          state_nxt    = VALID;
        end
      end
      VALID: begin
        // Flag the early req drop only once, even if backpressure keeps the
        // FSM in VALID for many cycles.
        if (!req_s && !err_seen) begin
          err_nxt      = 1'b1;
          err_seen_nxt = 1'b1;
        end
        if (in_ready) begin
          valid_nxt = 1'b0;
          ack_nxt   = 1'b1;
          count_nxt = out_count + CNT_WIDTH'(1);
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      err_seen  <= 1'b0;
      out_ack   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      err_seen  <= err_seen_nxt;
      out_ack   <= ack_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_count <= count_nxt;
      out_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_handshake_receiver.sv
// Bench for handshake_receiver with SYNC_STAGES=2 and CNT_WIDTH=4.
// The small counter makes the wrap reachable in a short run.
// Inputs are driven and outputs are sampled at negedge. A posedge monitor
// pops the expected words from a scoreboard queue on each accept.
module tb_handshake_receiver;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          in_clk = 1'b0;
  logic          in_reset_n = 1'b0;
  logic          in_req = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready = 1'b0;
  logic          out_ack, out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;

  handshake_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(CW)) dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .in_req(in_req), .in_data(in_data),
    .out_ack(out_ack), .out_data(out_data), .out_valid(out_valid),
    .in_ready(in_ready), .out_err(out_err), .out_count(out_count));

  always #5 in_clk = ~in_clk;

  int n_cmp = 0, n_bad = 0;
  int err_cnt = 0, acc_cnt = 0;
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor. Samples pre-edge values on each accepting edge.
  always @(posedge in_clk) begin
    if (in_reset_n) begin
      if (out_err) err_cnt++;
      if (out_valid && in_ready) begin
        acc_cnt++;
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("sb_data", out_data, sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    in_reset_n = 1'b0;
    @(negedge in_clk); @(negedge in_clk);
    in_reset_n = 1'b1;
    repeat (5) @(negedge in_clk);
  endtask

  // One full transfer. rw=0 holds ready high from the start.
  // rw>0 applies rw cycles of backpressure after valid appears.
  task automatic do_xfer(input logic [DW-1:0] d, input int rw);
    int n;
    logic stable;
    in_data = d; in_req = 1'b1; in_ready = (rw == 0); sb_q.push_back(d);
    n = 0;
    do begin @(negedge in_clk); n++; end while (!out_valid && n < 20);
    chk("valid_lat", n, 3);
    chk("valid_data", out_data, d);
    if (rw > 0) begin
      stable = 1'b1;
      for (int k = 0; k < rw; k++) begin
        @(negedge in_clk);
        if (!out_valid || out_data !== d || out_ack) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
      in_ready = 1'b1;
    end
    @(negedge in_clk);
    chk("ack_rise", {out_ack, out_valid}, 2'b10);
    in_req = 1'b0;
    n = 0;
    do begin @(negedge in_clk); n++; end while (out_ack && n < 20);
    chk("ack_fall_lat", n, 3);
  endtask

  typedef struct {logic [DW-1:0] data; int rw; logic [CW-1:0] exp_cnt;} vec_t;
  vec_t tbl[5];

  initial begin
    int n, e0, a0;
    logic seen;
    tbl[0] = '{8'hA5, 0, 4'd1};
    tbl[1] = '{8'h3C, 10, 4'd2};
    tbl[2] = '{8'hFF, 1, 4'd3};
    tbl[3] = '{8'h00, 3, 4'd4};
    tbl[4] = '{8'h5A, 0, 4'd5};

    #1 chk("rst_outs", {out_ack, out_valid, out_err, out_data, out_count}, 0);
    do_reset();

    // Basic transfers and backpressure
    for (int i = 0; i < 5; i++) begin
      do_xfer(tbl[i].data, tbl[i].rw);
      chk("count", out_count, tbl[i].exp_cnt);
    end

    // Req drops while VALID: one err pulse, transfer still completes
    e0 = err_cnt;
    in_data = 8'hC3; in_req = 1'b1; in_ready = 1'b0; sb_q.push_back(8'hC3);
    n = 0;
    do begin @(negedge in_clk); n++; end while (!out_valid && n < 20);
    in_req = 1'b0;
    repeat (6) @(negedge in_clk);
    chk("err_pulses", err_cnt - e0, 1);
    in_ready = 1'b1;
    @(negedge in_clk);
    chk("err_ack_hi", {out_ack, out_valid}, 2'b10);
    @(negedge in_clk);
    chk("err_ack_1cyc", out_ack, 0);
    chk("err_count", out_count, 6);

    // Reset during ACK with req still high
    in_data = 8'h11; in_req = 1'b1; in_ready = 1'b1; sb_q.push_back(8'h11);
    n = 0;
    do begin @(negedge in_clk); n++; end while (!out_ack && n < 20);
    chk("pre_rst_ack", out_ack, 1);
    in_reset_n = 1'b0;
    #1 chk("mid_rst_outs", {out_ack, out_valid, out_err, out_data, out_count}, 0);
    @(negedge in_clk); @(negedge in_clk);
    in_reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge in_clk); if (out_valid || out_ack) seen = 1'b1; end
    chk("no_stale_xfer", seen, 0);
    in_req = 1'b0;
    repeat (4) @(negedge in_clk);
    do_xfer(8'h77, 0);
    chk("post_rst_count", out_count, 1);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) do_xfer(DW'(i + 8'h40), 0);
    chk("wrap_count", out_count, 1);

    // Back-to-back sender with random ready
    e0 = err_cnt; a0 = acc_cnt;
    for (int d = 1; d <= 4; d++) begin
      in_data = DW'(d); in_req = 1'b1; sb_q.push_back(DW'(d));
      n = 0;
      do begin in_ready = 1'($urandom_range(0, 1)); @(negedge in_clk); n++; end
      while (!out_ack && n < 60);
      in_req = 1'b0;
      n = 0;
      do begin in_ready = 1'($urandom_range(0, 1)); @(negedge in_clk); n++; end
      while (out_ack && n < 20);
      chk("b2b_ack_fall", out_ack, 0);
    end
    in_ready = 1'b0;
    chk("b2b_accepts", acc_cnt - a0, 4);
    chk("b2b_no_err", err_cnt - e0, 0);
    chk("sb_drained", sb_q.size(), 0);
    chk("err_total", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
